// File: rtl/program_icache.sv
// -----------------------------------------------------------------------------
// program_icache
//   Direct-mapped instruction cache with one instruction word per line.
//   The low address bits select a line and the remaining upper bits form the
//   tag. A request is accepted in IDLE. It is looked up in the next cycle.
//   On a hit the cached word is returned. On a miss the line is refilled from
//   program memory before the word is returned. Each response strobes once.
//   The cache then waits for the core to drop its request before it accepts
//   another one.
//
// Parameters
//   PROGRAM_MEM_ADDR_BITS  instruction address width
//   PROGRAM_MEM_DATA_BITS  instruction word width
//   CACHE_LINES            line count; power of two, 2 .. 2**PROGRAM_MEM_ADDR_BITS
//
// Ports
//   clk                in   single clock, rising edge
//   reset              in   asynchronous, active-high
//   flush              in   invalidate every line at the next edge
//   core_read_valid    in   fetch request from the core
//   core_read_address  in   fetch address (latched when accepted)
//   core_read_ready    out  one-cycle response strobe
//   core_read_data     out  returned instruction, held until the next response
//   mem_read_valid     out  refill request, high only while filling
//   mem_read_address   out  refill address (0 outside a fill)
//   mem_read_ready     in   program memory response strobe
//   mem_read_data      in   refill word
//   hit_count          out  saturating hit counter
//   miss_count         out  saturating miss counter
//
// Build option
//   PROGRAM_ICACHE_STATS_EN  when defined, the counters are live. Otherwise
//                            the counters are removed and both ports read 0.
// -----------------------------------------------------------------------------
module program_icache #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             core_read_valid,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] core_read_address,
    output logic                             core_read_ready,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] core_read_data,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int INDEX_BITS = $clog2(CACHE_LINES);
    // The stored tag carries one extra constant-zero bit. This keeps the tag
    // width non-zero when the cache covers the whole address space.
    localparam int TAG_BITS   = PROGRAM_MEM_ADDR_BITS - INDEX_BITS + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESPOND,
        RELEASE
    } state_t;

    state_t                           state;
    state_t                           state_next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0] data_q;
    logic [CACHE_LINES-1:0]           valid;
    logic [TAG_BITS-1:0]              tag_arr  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] data_arr [CACHE_LINES];
    logic                             flushed_q;   // a flush has been seen since this request was accepted

    logic [INDEX_BITS-1:0]            index;
    logic [TAG_BITS-1:0]              tag;
    logic                             lookup_hit;
    logic                             fill_done;
    logic                             install;

    assign index      = addr_q[INDEX_BITS-1:0];
    assign tag        = TAG_BITS'({1'b0, addr_q} >> INDEX_BITS);
    assign lookup_hit = valid[index] && (tag_arr[index] == tag);
    assign fill_done  = (state == FILL) && mem_read_ready;
    // If a flush arrives during a request, the refill data is still returned
    // to the core but is not written into the cache.
    assign install    = fill_done && !flush && !flushed_q;

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: each always_comb gives every output a default first, so no path
    // can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (core_read_valid) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_hit ? RESPOND : FILL;
            FILL:    if (mem_read_ready) state_next = RESPOND;
            RESPOND: state_next = RELEASE;
            RELEASE: if (!core_read_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // These are decoded from the state alone. A reset therefore drops the
    // refill request at once and does not wait for the memory.
    always_comb begin
        core_read_ready  = (state == RESPOND);
        mem_read_valid   = (state == FILL);
        mem_read_address = (state == FILL) ? addr_q : '0;
    end

    assign core_read_data = data_q;

    // ---------------------------------------------------------------- datapath and valid bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            flushed_q <= 1'b0;
            valid     <= '0;
        end else begin
            if (state == IDLE && core_read_valid) addr_q <= core_read_address;
            if (state == LOOKUP && lookup_hit)    data_q <= data_arr[index];
            if (fill_done)                        data_q <= mem_read_data;

            // A flush taken in IDLE comes before the new request, so it does
            // not block that request's refill.
            flushed_q <= (state != IDLE) && (flushed_q || flush);

            if (flush) begin
                valid <= '0;
            end else if (install) begin
                valid[index] <= 1'b1;
            end
        end
    end

    // NOTE: the tag and data arrays are left unreset on purpose. A line is
    // used only when its valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_arr[index]  <= tag;
            data_arr[index] <= mem_read_data;
        end
    end

    // ---------------------------------------------------------------- statistics
`ifdef PROGRAM_ICACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == LOOKUP) begin
            if (lookup_hit) begin
                if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end else begin
                if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_program_icache.sv
// -----------------------------------------------------------------------------
// tb_program_icache
//   Self-checking bench for program_icache with its default parameters.
//   The reference model tracks, for each line, which address it holds and
//   whether it is valid. From that it decides hit or miss for each request.
//   The expected response is simply the word held in the bench's program
//   memory. The cycle timing of every output follows from the hit/miss
//   latencies and the handshake rules. A single compare process checks all
//   outputs against the expected values on every falling edge.
// -----------------------------------------------------------------------------
module tb_program_icache;

    localparam int A     = 8;
    localparam int D     = 16;
    localparam int LINES = 16;

`ifdef PROGRAM_ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         core_read_valid;
    logic [A-1:0] core_read_address;
    logic         core_read_ready;
    logic [D-1:0] core_read_data;
    logic         mem_read_valid;
    logic [A-1:0] mem_read_address;
    logic         mem_read_ready;
    logic [D-1:0] mem_read_data;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    always #5 clk = ~clk;

    program_icache #(
        .PROGRAM_MEM_ADDR_BITS(A),
        .PROGRAM_MEM_DATA_BITS(D),
        .CACHE_LINES(LINES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .core_read_valid(core_read_valid),
        .core_read_address(core_read_address),
        .core_read_ready(core_read_ready),
        .core_read_data(core_read_data),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    int checks = 0;
    int errors = 0;

    // Program memory contents and the cache model.
    logic [D-1:0] prog_mem [256];
    bit           m_valid [LINES];
    logic [A-1:0] m_addr  [LINES];

    // Expected output values.
    bit           compare_en = 1'b0;
    logic         exp_ready;
    logic         exp_mem_valid;
    logic [A-1:0] exp_mem_addr;
    logic [D-1:0] exp_data;
    int           exp_hits;
    int           exp_misses;

    // Event counters taken from the DUT outputs, checked against literals.
    int           bursts    = 0;
    int           responses = 0;
    logic         mv_prev   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        exp_ready     = 1'b0;
        exp_mem_valid = 1'b0;
        exp_mem_addr  = '0;
        exp_data      = '0;
        exp_hits      = 0;
        exp_misses    = 0;
    endtask

    // Advance one clock. A flush sampled at this edge clears the model lines.
    task automatic tick(output bit f);
        @(posedge clk);
        f = flush;
        if (flush) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        #1;
    endtask

    // ---------------------------------------------------------------- compare process
    always @(negedge clk) begin
        if (compare_en) begin
            check("core_read_ready", core_read_ready, exp_ready);
            check("core_read_data", core_read_data, exp_data);
            check("mem_read_valid", mem_read_valid, exp_mem_valid);
            if (exp_mem_valid) check("mem_read_address", mem_read_address, exp_mem_addr);
            check("hit_count", hit_count, STATS ? sat16(exp_hits) : 16'h0);
            check("miss_count", miss_count, STATS ? sat16(exp_misses) : 16'h0);
        end
    end

    always @(negedge clk) begin
        if (mem_read_valid && !mv_prev) bursts++;
        mv_prev = mem_read_valid;
        if (core_read_ready) responses++;
    end

    // ---------------------------------------------------------------- stimulus
    task automatic idle(input int n, input bit pulse_flush);
        bit f;
        core_read_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            flush = pulse_flush && (i == 0);
            tick(f);
        end
        flush = 1'b0;
    endtask

    // Issue one fetch, starting from an idle cycle.
    //   delay     extra FILL cycles before the memory answers
    //   hold      cycles after the response during which core_read_valid stays high
    //   flush_at  cycle of the request in which flush is pulsed
    //             (0 = lookup cycle, k+1 = k-th fill cycle, -1 = none)
    //   flush_req pulse flush in the same cycle as the request
    task automatic fetch(input logic [A-1:0] a, input int delay, input int hold,
                         input int flush_at, input bit flush_req);
        bit f;
        bit hit;
        bit blocked;
        int idx;
        int m;
        idx = int'(a) % LINES;
        core_read_valid   = 1'b1;
        core_read_address = a;
        flush             = flush_req;
        tick(f);                                   // request accepted
        core_read_address = A'($urandom);          // only the accepted address may matter
        hit   = m_valid[idx] && (m_addr[idx] == a);
        flush = (flush_at == 0);
        tick(f);                                   // lookup resolved
        blocked = f;
        if (hit) exp_hits++;
        else     exp_misses++;
        if (!hit) begin
            exp_mem_valid = 1'b1;
            exp_mem_addr  = a;
            for (int k = 0; k <= delay; k++) begin
                flush          = (flush_at == k + 1);
                mem_read_ready = (k == delay);
                mem_read_data  = (k == delay) ? prog_mem[a] : D'($urandom);
                tick(f);
                blocked |= f;
            end
            mem_read_ready = 1'b0;
            exp_mem_valid  = 1'b0;
            if (!blocked) begin
                m_valid[idx] = 1'b1;
                m_addr[idx]  = a;
            end
        end
        flush     = 1'b0;
        exp_ready = 1'b1;                          // response cycle
        exp_data  = prog_mem[a];
        m = (hold + 1 > 2) ? hold + 1 : 2;
        core_read_valid = (hold > 0);
        tick(f);
        exp_ready = 1'b0;
        for (int i = 1; i < m; i++) begin
            core_read_valid = (i < hold);
            tick(f);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          f;
        int          b0;
        int          r0;
        logic [A-1:0] a;
        reset = 1'b1; flush = 1'b0; core_read_valid = 1'b0; core_read_address = '0;
        mem_read_ready = 1'b0; mem_read_data = '0;
        for (int i = 0; i < 256; i++) prog_mem[i] = D'($urandom);
        prog_mem[8'h05] = 16'hA1B2;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", core_read_ready, 0);
        check("reset_data", core_read_data, 0);
        check("reset_mem_valid", mem_read_valid, 0);
        check("reset_mem_addr", mem_read_address, 0);
        check("reset_hit_count", hit_count, 0);
        check("reset_miss_count", miss_count, 0);
        reset = 1'b0;
        compare_en = 1'b1;
        idle(2, 1'b0);

        // Cold miss at 0x05; memory answers in the third fill cycle.
        fetch(8'h05, 2, 0, -1, 1'b0);
        check("cold_data", core_read_data, 16'hA1B2);
        check("cold_bursts", bursts, 1);
        check("cold_responses", responses, 1);
        check("cold_miss_count", miss_count, STATS ? 16'd1 : 16'd0);

        // Repeat fetch: hit, no refill.
        fetch(8'h05, 0, 0, -1, 1'b0);
        check("hit_bursts", bursts, 1);
        check("hit_responses", responses, 2);
        check("hit_data", core_read_data, 16'hA1B2);
        check("hit_hit_count", hit_count, STATS ? 16'd1 : 16'd0);

        // Conflict: 0x05 and 0x15 share index 5.
        idle(1, 1'b1);
        b0 = bursts;
        fetch(8'h05, 1, 0, -1, 1'b0);
        fetch(8'h15, 1, 0, -1, 1'b0);
        fetch(8'h05, 1, 0, -1, 1'b0);
        check("conflict_bursts", bursts, b0 + 3);
        check("conflict_miss_count", miss_count, STATS ? 16'd4 : 16'd0);

        // A flush in idle forces a refill.
        idle(1, 1'b1);
        b0 = bursts;
        fetch(8'h05, 0, 0, -1, 1'b0);
        check("flush_idle_bursts", bursts, b0 + 1);

        // A flush during the fill still returns the data, but does not install it.
        idle(1, 1'b1);
        b0 = bursts;
        fetch(8'h05, 3, 0, 2, 1'b0);
        check("flush_fill_data", core_read_data, 16'hA1B2);
        fetch(8'h05, 0, 0, -1, 1'b0);
        check("flush_fill_bursts", bursts, b0 + 2);

        // A flush in the same cycle as the request wins, so the request misses.
        b0 = bursts;
        fetch(8'h05, 0, 0, -1, 1'b1);
        check("flush_with_req_bursts", bursts, b0 + 1);

        // Holding the request high after the response gives one response only.
        r0 = responses;
        fetch(8'h05, 0, 5, -1, 1'b0);
        check("hold_responses", responses, r0 + 1);

        // Reset during a fill.
        a = 8'h37;
        core_read_valid = 1'b1; core_read_address = a;
        tick(f);
        tick(f);
        exp_misses++;
        exp_mem_valid = 1'b1; exp_mem_addr = a;
        tick(f);
        reset = 1'b1;
        core_read_valid = 1'b0;
        model_reset();
        #1;
        check("rst_fill_mem_valid", mem_read_valid, 0);
        check("rst_fill_mem_addr", mem_read_address, 0);
        tick(f);
        tick(f);
        reset = 1'b0;
        mem_read_ready = 1'b1; mem_read_data = D'($urandom);
        tick(f);                                    // a late memory answer must be ignored
        mem_read_ready = 1'b0;
        tick(f);
        r0 = responses;
        check("rst_late_ready_ignored", responses, r0);
        b0 = bursts;
        fetch(a, 1, 0, -1, 1'b0);
        check("rst_next_miss_bursts", bursts, b0 + 1);
        check("rst_next_miss_count", miss_count, STATS ? 16'd1 : 16'd0);

        // Randomized traffic over a small address pool, to get hits and conflicts.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) a = A'($urandom);
            else a = A'(($urandom_range(0, 2) << 4) | $urandom_range(0, 3));
            fetch(a, $urandom_range(0, 4), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1,
                  $urandom_range(0, 19) == 0);
            idle($urandom_range(0, 2), $urandom_range(0, 11) == 0);
        end

        compare_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
